// File: rtl/alu_decoder_seq.sv
// ALU control decoder with a multi-cycle mult/div sequencer.
// The decoder maps ALUop/funct onto the ALU control code. The sequencer
// issues mult/multu/div/divu to an iterative MDU, counts down its busy
// time, and stalls the front end on MDU or HI/LO accesses while busy.
module alu_decoder_seq #(
  parameter int CTRL_W     = 3,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [1:0]        ALUop,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] ALUcontrol,
  output logic              illegal,
  output logic [1:0]        hilo_sel,
  output logic              mdu_start,
  output logic [1:0]        mdu_op,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic              stall
);

  // 3-bit ALU operation codes
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // HI/LO select encodings
  localparam logic [1:0] HL_NONE = 2'b00;
  localparam logic [1:0] HL_HI   = 2'b01;
  localparam logic [1:0] HL_LO   = 2'b10;

  // Counter reload values: the counter runs N-1 .. 0, giving N busy cycles
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10
  } state_t;

  // Decode result before it is widened / qualified
  typedef struct packed {
    logic [2:0] code;
    logic       unknown;
  } dec_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       op_q;
  logic             done_q;

  dec_t             dec;
  logic             is_rtype;
  logic             mdu_req;
  logic             busy;

  // ALUop/funct to ALU code; does not look at instr_valid
  always_comb begin
    dec.code    = OP_ADD;
    dec.unknown = 1'b0;
    unique case (ALUop)
      2'b00: dec.code = OP_ADD;
      2'b01: dec.code = OP_SUB;
      2'b11: dec.code = OP_SLT;
      default: begin
        unique case (funct)
          6'b100000: dec.code = OP_ADD;
          6'b100010: dec.code = OP_SUB;
          6'b100100: dec.code = OP_AND;
          6'b100101: dec.code = OP_OR;
          6'b100111: dec.code = OP_NOR;
          6'b100110: dec.code = OP_XOR;
          6'b000100: dec.code = OP_SLL;
          6'b000000: dec.code = OP_SLL;
          // mult/multu/div/divu and mfhi/mflo are known; the ALU idles on add
          6'b011000, 6'b011001, 6'b011010, 6'b011011,
          6'b010000, 6'b010010: dec.code = OP_ADD;
          default: begin
            dec.code    = OP_ADD;
            dec.unknown = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Zero-extend the 3-bit code into the configured control width
  always_comb begin
    ALUcontrol      = '0;
    ALUcontrol[2:0] = dec.code;
  end

  assign is_rtype = instr_valid && (ALUop == 2'b10);
  assign illegal  = instr_valid && dec.unknown;
  assign mdu_req  = is_rtype && (funct[5:2] == 4'b0110);

  // HI/LO read selection for mfhi/mflo
  always_comb begin
    hilo_sel = HL_NONE;
    if (is_rtype) begin
      if (funct == 6'b010000)      hilo_sel = HL_HI;
      else if (funct == 6'b010010) hilo_sel = HL_LO;
    end
  end

  // Busy comes straight from registered state, so async reset clears it
  // immediately and the combinational stall/start see busy = 0 in reset.
  assign busy      = (state_q != IDLE);
  assign mdu_busy  = busy;
  assign mdu_op    = op_q;
  assign mdu_done  = done_q;
  assign mdu_start = mdu_req && !busy;
  assign stall     = busy && (mdu_req || (hilo_sel != HL_NONE));

  // Next counter value while an operation is in flight
  assign cnt_d = cnt_q - 1'b1;

  // Sequencer: accept in IDLE, count down, pulse done on the last busy cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mdu_req) begin
            op_q <= funct[1:0];
            if (funct[1]) begin
              state_q <= DIV;
              cnt_q   <= DIV_LOAD;
            end else begin
              state_q <= MUL;
              cnt_q   <= MUL_LOAD;
            end
          end
        end
        MUL, DIV: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_decoder_seq.sv
// Scoreboard bench for alu_decoder_seq: the driver applies one directed
// vector per cycle and queues its hand-computed outputs; the monitor pops
// and compares each cycle on the falling edge.
module tb_alu_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [1:0] ALUop = 2'b00;
  logic [5:0] funct = 6'b000000;

  // Default-parameter instance
  logic [2:0] ctrl0;
  logic       ill0, start0, busy0, done0, stall0;
  logic [1:0] hilo0, op0;
  // Short-multiply, wide-control instance
  logic [4:0] ctrl1;
  logic       ill1, start1, busy1, done1, stall1;
  logic [1:0] hilo1, op1;

  always #5 clk = ~clk;

  alu_decoder_seq u0 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .ALUop(ALUop),
    .funct(funct), .ALUcontrol(ctrl0), .illegal(ill0), .hilo_sel(hilo0),
    .mdu_start(start0), .mdu_op(op0), .mdu_busy(busy0), .mdu_done(done0),
    .stall(stall0)
  );

  alu_decoder_seq #(.CTRL_W(5), .MUL_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .ALUop(ALUop),
    .funct(funct), .ALUcontrol(ctrl1), .illegal(ill1), .hilo_sel(hilo1),
    .mdu_start(start1), .mdu_op(op1), .mdu_busy(busy1), .mdu_done(done1),
    .stall(stall1)
  );

  // {ctrl[4:0], illegal, hilo[1:0], start, op[1:0], busy, done, stall}
  typedef struct {
    string       name;
    bit          dut;
    logic [13:0] vec;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Monitor: one expectation per cycle, compared mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        logic [13:0] act;
        e = q.pop_front();
        if (e.dut)
          act = {ctrl1, ill1, hilo1, start1, op1, busy1, done1, stall1};
        else
          act = {2'b00, ctrl0, ill0, hilo0, start0, op0, busy0, done0, stall0};
        n_cmp++;
        if (act !== e.vec) begin
          n_fail++;
          $display("FAIL %s (dut%0d) got ctrl/ill/hilo/start/op/busy/done/stall=%b expected %b at %0t",
                   e.name, e.dut, act, e.vec, $time);
        end
      end
    end
  end

  // Driver: apply one cycle of inputs and queue the expected outputs
  task automatic step(input string nm, input bit d, input logic rst,
                      input logic v, input logic [1:0] a, input logic [5:0] f,
                      input logic [4:0] ctrl, input logic ill, input logic [1:0] hs,
                      input logic st, input logic [1:0] mop, input logic bsy,
                      input logic dn, input logic stl);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n       = rst;
    instr_valid = v;
    ALUop       = a;
    funct       = f;
    e.name = nm;
    e.dut  = d;
    e.vec  = {ctrl, ill, hs, st, mop, bsy, dn, stl};
    q.push_back(e);
  endtask

  // No instruction this cycle; only sequencer outputs vary
  task automatic idle(input string nm, input bit d, input logic [1:0] mop,
                      input logic bsy, input logic dn);
    step(nm, d, 1'b1, 1'b0, 2'b00, 6'b000000, 5'b00010, 1'b0, 2'b00,
         1'b0, mop, bsy, dn, 1'b0);
  endtask

  // Decode check in IDLE with no sequencer activity
  task automatic dec(input string nm, input logic v, input logic [1:0] a,
                     input logic [5:0] f, input logic [4:0] ctrl, input logic ill,
                     input logic [1:0] hs);
    step(nm, 1'b0, 1'b1, v, a, f, ctrl, ill, hs, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    step("reset", 0, 1'b0, 1'b0, 2'b00, 6'b000000, 5'b00010, 0, 2'b00, 0, 2'b00, 0, 0, 0);
    idle("post_reset", 0, 2'b00, 0, 0);

    // Decode sweep
    dec("dec_lw",    1, 2'b00, 6'b100000, 5'b00010, 0, 2'b00);
    dec("dec_beq",   1, 2'b01, 6'b000000, 5'b00110, 0, 2'b00);
    dec("dec_slti",  1, 2'b11, 6'b000000, 5'b00111, 0, 2'b00);
    dec("dec_add",   1, 2'b10, 6'b100000, 5'b00010, 0, 2'b00);
    dec("dec_sub",   1, 2'b10, 6'b100010, 5'b00110, 0, 2'b00);
    dec("dec_and",   1, 2'b10, 6'b100100, 5'b00000, 0, 2'b00);
    dec("dec_or",    1, 2'b10, 6'b100101, 5'b00001, 0, 2'b00);
    dec("dec_nor",   1, 2'b10, 6'b100111, 5'b00101, 0, 2'b00);
    dec("dec_xor",   1, 2'b10, 6'b100110, 5'b00100, 0, 2'b00);
    dec("dec_sllv",  1, 2'b10, 6'b000100, 5'b00011, 0, 2'b00);
    dec("dec_sll",   1, 2'b10, 6'b000000, 5'b00011, 0, 2'b00);
    dec("dec_mfhi",  1, 2'b10, 6'b010000, 5'b00010, 0, 2'b01);
    dec("dec_mflo",  1, 2'b10, 6'b010010, 5'b00010, 0, 2'b10);
    dec("dec_ill",   1, 2'b10, 6'b111111, 5'b00010, 1, 2'b00);
    dec("dec_ill_nv",0, 2'b10, 6'b111111, 5'b00010, 0, 2'b00);
    dec("dec_i_fn",  1, 2'b00, 6'b111111, 5'b00010, 0, 2'b00);
    dec("mult_nv",   0, 2'b10, 6'b011000, 5'b00010, 0, 2'b00);
    dec("mflo_nv",   0, 2'b10, 6'b010010, 5'b00010, 0, 2'b00);

    // mult: issue, 4 busy cycles with a sub that must not stall, then done
    step("mul_issue", 0, 1, 1, 2'b10, 6'b011000, 5'b00010, 0, 2'b00, 1, 2'b00, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      step("mul_busy_sub", 0, 1, 1, 2'b10, 6'b100010, 5'b00110, 0, 2'b00, 0, 2'b00, 1, 0, 0);
    idle("mul_done", 0, 2'b00, 0, 1);
    idle("mul_after", 0, 2'b00, 0, 0);

    // divu followed by mflo held for all 32 busy cycles
    step("divu_issue", 0, 1, 1, 2'b10, 6'b011011, 5'b00010, 0, 2'b00, 1, 2'b00, 0, 0, 0);
    for (int i = 1; i <= 32; i++)
      step("divu_mflo_stall", 0, 1, 1, 2'b10, 6'b010010, 5'b00010, 0, 2'b10, 0, 2'b11, 1, 0, 1);
    step("divu_done_mflo", 0, 1, 1, 2'b10, 6'b010010, 5'b00010, 0, 2'b10, 0, 2'b11, 0, 1, 0);
    idle("divu_after", 0, 2'b11, 0, 0);

    // multu then mult back to back: stalled through cnt==0, issued with done
    step("multu_issue", 0, 1, 1, 2'b10, 6'b011001, 5'b00010, 0, 2'b00, 1, 2'b11, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      step("mult_stalled", 0, 1, 1, 2'b10, 6'b011000, 5'b00010, 0, 2'b00, 0, 2'b01, 1, 0, 1);
    step("mult_issue_done", 0, 1, 1, 2'b10, 6'b011000, 5'b00010, 0, 2'b00, 1, 2'b01, 0, 1, 0);
    for (int i = 1; i <= 4; i++)
      idle("mult2_busy", 0, 2'b00, 1, 0);
    idle("mult2_done", 0, 2'b00, 0, 1);
    idle("mult2_after", 0, 2'b00, 0, 0);

    // div aborted by reset in busy cycle 10
    step("div_issue", 0, 1, 1, 2'b10, 6'b011010, 5'b00010, 0, 2'b00, 1, 2'b00, 0, 0, 0);
    for (int i = 1; i <= 9; i++)
      idle("div_busy", 0, 2'b10, 1, 0);
    step("div_reset", 0, 1'b0, 1, 2'b10, 6'b010010, 5'b00010, 0, 2'b10, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 40; i++)
      idle("no_done_after_abort", 0, 2'b00, 0, 0);
    step("mul2_issue", 0, 1, 1, 2'b10, 6'b011000, 5'b00010, 0, 2'b00, 1, 2'b00, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      idle("mul2_busy", 0, 2'b00, 1, 0);
    idle("mul2_done", 0, 2'b00, 0, 1);
    idle("mul2_after", 0, 2'b00, 0, 0);

    // MUL_CYCLES=1, CTRL_W=5 instance
    step("u1_reset", 1, 1'b0, 1'b0, 2'b00, 6'b000000, 5'b00010, 0, 2'b00, 0, 2'b00, 0, 0, 0);
    step("u1_slti", 1, 1, 1, 2'b11, 6'b000000, 5'b00111, 0, 2'b00, 0, 2'b00, 0, 0, 0);
    step("u1_nor", 1, 1, 1, 2'b10, 6'b100111, 5'b00101, 0, 2'b00, 0, 2'b00, 0, 0, 0);
    step("u1_ill", 1, 1, 1, 2'b10, 6'b111111, 5'b00010, 1, 2'b00, 0, 2'b00, 0, 0, 0);
    step("u1_mult", 1, 1, 1, 2'b10, 6'b011001, 5'b00010, 0, 2'b00, 1, 2'b00, 0, 0, 0);
    step("u1_busy_mfhi", 1, 1, 1, 2'b10, 6'b010000, 5'b00010, 0, 2'b01, 0, 2'b01, 1, 0, 1);
    idle("u1_done", 1, 2'b01, 0, 1);
    idle("u1_after", 1, 2'b01, 0, 0);

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_decoder_seq.md
Name: alu_decoder_seq

Overview:
Parametrised successor to the combinational ALU control decoder. It decodes ALUop/funct into the ALU control code and adds a multi-cycle sequencer for mult/multu/div/divu. The sequencer issues operations to an iterative multiply/divide unit, tracks its busy time with a down-counter, and stalls the pipeline front end on HI/LO hazards. It sits between the main control decoder and the ALU/MDU in the datapath.

Parameters:
CTRL_W, 3, ALU control width (>=3); the 3-bit codes are zero-extended into it.
MUL_CYCLES, 4, busy cycles for mult/multu (>=1).
DIV_CYCLES, 32, busy cycles for div/divu (>=1).
CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
instr_valid  in  1  ALUop/funct describe a real instruction this cycle.
ALUop  in  2  from main decoder.
funct  in  6  instruction funct field.
ALUcontrol  out  CTRL_W  ALU operation code (combinational).
illegal  out  1  unknown R-type funct (combinational).
hilo_sel  out  2  01 = mfhi, 10 = mflo, 00 = none (combinational).
mdu_start  out  1  one-cycle issue pulse to the MDU (combinational, issue cycle).
mdu_op  out  2  registered op: 00 mult, 01 multu, 10 div, 11 divu.
mdu_busy  out  1  sequencer not IDLE (registered state).
mdu_done  out  1  registered one-cycle pulse on completion.
stall  out  1  hold the front end this cycle (combinational).

Behaviour:
- Decode (independent of instr_valid):
  - ALUop 00 -> 010; 01 -> 110; 11 -> 111.
  - ALUop 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 100111 -> 101, 100110 -> 100, 000100 -> 011, 000000 -> 011.
  - MDU/HILO functs 011000..011011, 010000 and 010010 -> 010 with no illegal flag.
  - Any other funct -> 010 and illegal = instr_valid.
  - No latches; every path assigns.
- hilo_sel: set only when instr_valid && ALUop==10 && funct is 010000 (01) or 010010 (10).
- mdu_req = instr_valid && ALUop==10 && funct in {011000, 011001, 011010, 011011}.
- FSM states: IDLE, MUL, DIV.
  - IDLE and mdu_req:
    - mdu_start = 1 in that cycle.
    - mdu_op <= funct[1:0].
    - cnt <= MUL_CYCLES-1 (to MUL) or DIV_CYCLES-1 (to DIV).
  - MUL/DIV with cnt != 0: cnt decrements by 1.
  - MUL/DIV with cnt == 0: go to IDLE, mdu_done <= 1 for exactly one cycle.
  - Busy duration is exactly MUL_CYCLES or DIV_CYCLES cycles after the issue edge.
- stall = mdu_busy && (mdu_req || hilo_sel != 00).
  - Stalled requests are not accepted; mdu_start = 0 while busy.
  - Non-MDU instructions never stall.
- Completion-cycle collision: a request arriving in the cycle where cnt == 0 is still stalled (state is busy). It is accepted on the following cycle, when IDLE; mdu_done and mdu_start then appear in the same cycle.
- mfhi/mflo in IDLE: no stall.
- Reset (async, any time, including mid-operation):
  - state IDLE, cnt 0, mdu_op 00, mdu_busy 0, mdu_done 0.
  - No done pulse is generated for an aborted operation.
  - Combinational outputs follow their inputs during reset, except that stall and mdu_start use busy = 0.

Test Plan:
- Decode sweep: each ALUop and table funct with instr_valid=1 -> exact code (e.g. 10/100111 -> 101); 10/111111 -> ALUcontrol 010, illegal=1; same with instr_valid=0 -> illegal=0.
- mult issue (MUL_CYCLES=4): mdu_req on cycle 0 -> mdu_start=1 on cycle 0, mdu_op=00; mdu_busy=1 on cycles 1-4; mdu_done=1 on cycle 5 only; mdu_busy=0 on cycle 5.
- divu followed immediately by mflo: mflo held with stall=1 for all 32 busy cycles, hilo_sel=10 throughout; stall=0 on the cycle mdu_done=1.
- Back-to-back multu then mult: second request stalled through cnt==0 cycle, then accepted in the done cycle (mdu_start=1 with mdu_done=1), mdu_op=00.
- Reset asserted mid-div (cycle 10): immediately mdu_busy=0, stall=0, mdu_op=00; after release no mdu_done pulse; a fresh mult completes normally.
- MUL_CYCLES=1, CTRL_W=5: mult -> busy exactly 1 cycle, done next; ALUop 11 -> ALUcontrol 00111.
